// File: rtl/rv_enc_pkg.sv
// -----------------------------------------------------------------------------
// rv_enc_pkg
// Shared constants for the RV32 instruction encoder (program loader):
//   enc_kind_e   command kinds accepted on the command port
//   OPC_*        major opcodes (same values the ID stage decodes)
//   F3_* / F7_*  funct3 / funct7 constants used when packing
//   enc_fmt_e    instruction layout selected by the encoder
//   wr_state_e   RAM writer FSM state
// Optional feature macro: ENC_MULDIV_EN (enables the OP_M command kind).
// -----------------------------------------------------------------------------
package rv_enc_pkg;

    typedef enum logic [3:0] {
        K_OP_IMM = 4'd0,
        K_OP     = 4'd1,
        K_LOAD   = 4'd2,
        K_STORE  = 4'd3,
        K_BRANCH = 4'd4,
        K_JAL    = 4'd5,
        K_JALR   = 4'd6,
        K_LUI    = 4'd7,
        K_AUIPC  = 4'd8,
        K_FENCE  = 4'd9,
        K_CSR    = 4'd10,
        K_SEND   = 4'd11,
        K_FIRE   = 4'd12,
        K_OP_M   = 4'd13
    } enc_kind_e;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;
    localparam logic [6:0] OPC_CUSTOM = 7'h2F;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_SEND = 3'b000;
    localparam logic [2:0] F3_FIRE = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } enc_fmt_e;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/rv_enc_fifo.sv
// -----------------------------------------------------------------------------
// rv_enc_fifo
// Synchronous FIFO holding encoded instruction words.
//   clk, rst      clock, synchronous active-high reset (drops all contents)
//   push, din     write din when push and not full
//   pop, dout     dout shows the head; pop removes it when not empty
//   full, empty   occupancy flags
//   count         number of stored words (0..DEPTH)
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rv_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// -----------------------------------------------------------------------------
// rv_inst_encoder
// Debug/boot program loader. Field-level commands are range-checked and packed
// into RV32 instruction words, queued in a FIFO and written to instruction RAM
// at consecutive word addresses.
//   clk, rst                 clock, synchronous active-high reset
//   start_i, start_addr_i    load write address (bits[1:0] forced 0), clear err_o
//   cmd_*                    command port (valid/ready) with instruction fields
//   mem_we_o/addr_o/wdata_o  RAM write request, held until mem_ready_i
//   mem_ready_i              RAM accepts the write this cycle
//   busy_o                   FIFO non-empty or write pending
//   err_o                    sticky: illegal command or start_i while busy
//   count_o                  words written since last start_i (saturating)
//   dbg_state_o              writer FSM state
// Handshakes: a transfer happens at a rising edge where valid and ready are both
// high; valid-side holds its payload stable until then, and ready never depends
// on valid.
// Optional feature macro: ENC_MULDIV_EN (OP_M kind: MUL..REMU, funct7=0000001).
// -----------------------------------------------------------------------------
module rv_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] start_addr_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_kind_i,
    input  logic [2:0]  cmd_funct3_i,
    input  logic        cmd_alt_i,
    input  logic [4:0]  cmd_rd_i,
    input  logic [4:0]  cmd_rs1_i,
    input  logic [4:0]  cmd_rs2_i,
    input  logic [31:0] cmd_imm_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [15:0] count_o,
    output wr_state_e   dbg_state_o
);
    // ------------------------------------------------------------------
    // Encoder (combinational)
    // ------------------------------------------------------------------
    enc_fmt_e    fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic        legal;
    logic [31:0] enc_word;
    logic        fits_i;
    logic        fits_b;
    logic        fits_j;
    logic        shamt_ok;

    assign fits_i   = ($signed(cmd_imm_i) >= -32'sd2048) && ($signed(cmd_imm_i) <= 32'sd2047);
    assign fits_b   = ($signed(cmd_imm_i) >= -32'sd4096) && ($signed(cmd_imm_i) <= 32'sd4094)
                      && !cmd_imm_i[0];
    assign fits_j   = ($signed(cmd_imm_i) >= -32'sd1048576) && ($signed(cmd_imm_i) <= 32'sd1048574)
                      && !cmd_imm_i[0];
    assign shamt_ok = (cmd_imm_i[31:5] == 27'd0);

    always_comb begin
        fmt   = FMT_R;
        opc   = 7'h00;
        f3    = cmd_funct3_i;
        f7    = F7_BASE;
        imm12 = cmd_imm_i[11:0];
        legal = 1'b0;
        case (cmd_kind_i)
            K_OP_IMM: begin
                fmt = FMT_I;
                opc = OPC_OP_IMM;
                if (cmd_funct3_i == F3_SLL) begin
                    legal = shamt_ok && !cmd_alt_i;
                    imm12 = {F7_BASE, cmd_imm_i[4:0]};
                end else if (cmd_funct3_i == F3_SR) begin
                    // alt selects SRAI; funct7 lives in the upper immediate bits
                    legal = shamt_ok;
                    imm12 = {(cmd_alt_i ? F7_ALT : F7_BASE), cmd_imm_i[4:0]};
                end else begin
                    legal = fits_i && !cmd_alt_i;
                end
            end
            K_OP: begin
                fmt   = FMT_R;
                opc   = OPC_OP;
                f7    = cmd_alt_i ? F7_ALT : F7_BASE;
                legal = !cmd_alt_i || (cmd_funct3_i == F3_ADD) || (cmd_funct3_i == F3_SR);
            end
            K_LOAD: begin
                fmt   = FMT_I;
                opc   = OPC_LOAD;
                legal = fits_i && !cmd_alt_i &&
                        (cmd_funct3_i != 3'd3) && (cmd_funct3_i != 3'd6) && (cmd_funct3_i != 3'd7);
            end
            K_STORE: begin
                fmt   = FMT_S;
                opc   = OPC_STORE;
                legal = fits_i && !cmd_alt_i && (cmd_funct3_i <= 3'd2);
            end
            K_BRANCH: begin
                fmt   = FMT_B;
                opc   = OPC_BRANCH;
                legal = fits_b && !cmd_alt_i && (cmd_funct3_i != 3'd2) && (cmd_funct3_i != 3'd3);
            end
            K_JAL: begin
                fmt   = FMT_J;
                opc   = OPC_JAL;
                legal = fits_j && !cmd_alt_i;
            end
            K_JALR: begin
                fmt   = FMT_I;
                opc   = OPC_JALR;
                f3    = F3_JALR;
                legal = fits_i && !cmd_alt_i;
            end
            K_LUI: begin
                fmt   = FMT_U;
                opc   = OPC_LUI;
                legal = (cmd_imm_i[11:0] == 12'd0) && !cmd_alt_i;
            end
            K_AUIPC: begin
                fmt   = FMT_U;
                opc   = OPC_AUIPC;
                legal = (cmd_imm_i[11:0] == 12'd0) && !cmd_alt_i;
            end
            K_FENCE: begin
                fmt   = FMT_I;
                opc   = OPC_FENCE;
                legal = !cmd_alt_i;
            end
            K_CSR: begin
                // imm[11:0] carries the CSR address, rs1 the register or uimm
                fmt   = FMT_I;
                opc   = OPC_SYSTEM;
                legal = !cmd_alt_i && (cmd_funct3_i != 3'd0) && (cmd_funct3_i != 3'd4);
            end
            K_SEND: begin
                fmt   = FMT_R;
                opc   = OPC_CUSTOM;
                f3    = F3_SEND;
                legal = !cmd_alt_i;
            end
            K_FIRE: begin
                fmt   = FMT_I;
                opc   = OPC_CUSTOM;
                f3    = F3_FIRE;
                legal = fits_i && !cmd_alt_i;
            end
`ifdef ENC_MULDIV_EN
            K_OP_M: begin
                fmt   = FMT_R;
                opc   = OPC_OP;
                f7    = F7_MULDIV;
                legal = !cmd_alt_i;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R: enc_word = {f7, cmd_rs2_i, cmd_rs1_i, f3, cmd_rd_i, opc};
            FMT_I: enc_word = {imm12, cmd_rs1_i, f3, cmd_rd_i, opc};
            FMT_S: enc_word = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, f3, cmd_imm_i[4:0], opc};
            FMT_B: enc_word = {cmd_imm_i[12], cmd_imm_i[10:5], cmd_rs2_i, cmd_rs1_i, f3,
                               cmd_imm_i[4:1], cmd_imm_i[11], opc};
            FMT_U: enc_word = {cmd_imm_i[31:12], cmd_rd_i, opc};
            FMT_J: enc_word = {cmd_imm_i[20], cmd_imm_i[10:1], cmd_imm_i[11], cmd_imm_i[19:12],
                               cmd_rd_i, opc};
            default: enc_word = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Command acceptance and FIFO
    // ------------------------------------------------------------------
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_dout;
    logic          fifo_pop;
    logic          cmd_fire;

    // start_i wins over the command port; no pop-to-push bypass when full.
    assign cmd_ready_o = !rst && !start_i && !fifo_full;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;

    rv_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_fire && legal),
        .din   (enc_word),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Writer FSM
    // ------------------------------------------------------------------
    wr_state_e state_q;
    wr_state_e state_d;
    logic      wr_accept;
    logic [15:0] count_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    assign wr_accept = (state_q == WR_WRITE) && mem_ready_i;

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = WR_WRITE;
                end
            end
            WR_WRITE: begin
                if (mem_ready_i) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = WR_IDLE;
                    end
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            count_q <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                wdata_q <= fifo_dout;
            end
            if (wr_accept) begin
                addr_q <= addr_q + 32'd4;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
            // A write can only be accepted while busy, so a honoured start
            // never collides with the address/count update above.
            if (start_i) begin
                if (busy_o) begin
                    err_q <= 1'b1;
                end else begin
                    addr_q  <= {start_addr_i[31:2], 2'b00};
                    count_q <= 16'h0;
                    err_q   <= 1'b0;
                end
            end
            if (cmd_fire && !legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_we_o    = (state_q == WR_WRITE);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (fifo_count != '0) || (state_q == WR_WRITE);
    assign err_o       = err_q;
    assign count_o     = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_rv_inst_encoder
// Directed vectors for the RV32 encoder/loader with hand-computed words, plus
// sequences for latency, back-to-back, backpressure, start-while-busy and
// reset-during-write.
// -----------------------------------------------------------------------------
module tb_rv_inst_encoder;
  import rv_enc_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] start_addr_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [3:0]  cmd_kind_i;
  logic [2:0]  cmd_funct3_i;
  logic        cmd_alt_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_rs1_i;
  logic [4:0]  cmd_rs2_i;
  logic [31:0] cmd_imm_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        busy_o;
  logic        err_o;
  logic [15:0] count_o;
  wr_state_e   dbg_state_o;

  rv_inst_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_kind_i   (cmd_kind_i),
    .cmd_funct3_i (cmd_funct3_i),
    .cmd_alt_i    (cmd_alt_i),
    .cmd_rd_i     (cmd_rd_i),
    .cmd_rs1_i    (cmd_rs1_i),
    .cmd_rs2_i    (cmd_rs2_i),
    .cmd_imm_i    (cmd_imm_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .count_o      (count_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  vec_t vecs[$];
  vec_t v;
  logic [31:0] st_addr;
  logic [31:0] st_a0;
  logic [31:0] st_d0;
  logic        st_seen;
  logic        st_stable;

  function automatic vec_t mk(logic [3:0] kind, logic [2:0] f3, logic alt, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm,
                              logic legal, logic [31:0] word);
    vec_t r;
    r.kind = kind; r.f3 = f3; r.alt = alt; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.imm = imm; r.legal = legal; r.word = word;
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every accepted RAM write is matched against exp_q in order
  always @(negedge clk) begin
    if (!rst && mem_we_o && mem_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o, mem_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        check32("wr_addr", mem_addr_o, mon_e[63:32]);
        check32("wr_data", mem_wdata_o, mon_e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input vec_t c);
    logic got;
    got = 1'b0;
    cmd_kind_i = c.kind; cmd_funct3_i = c.f3; cmd_alt_i = c.alt; cmd_rd_i = c.rd;
    cmd_rs1_i = c.rs1; cmd_rs2_i = c.rs2; cmd_imm_i = c.imm;
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    if (got) begin
      accepted++;
    end else begin
      total++;
      bad++;
      $display("FAIL cmd_timeout: got ready 0 expected ready within 200 cycles");
    end
  endtask

  task automatic do_start(input logic [31:0] a);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    @(posedge clk);
    #1;
    start_i = 1'b1;
    start_addr_i = a;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check32("drain", exp_q.size(), 0);
    tick(1);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; start_addr_i = 32'h0; cmd_valid_i = 1'b0;
    cmd_kind_i = 4'h0; cmd_funct3_i = 3'h0; cmd_alt_i = 1'b0; cmd_rd_i = 5'h0;
    cmd_rs1_i = 5'h0; cmd_rs2_i = 5'h0; cmd_imm_i = 32'h0; mem_ready_i = 1'b1;

    vecs.push_back(mk(K_OP_IMM, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0,  32'd5,          1'b1, 32'h00500093));
    vecs.push_back(mk(K_LUI,    3'd0, 1'b0, 5'd2,  5'd0, 5'd0,  32'h12345000,   1'b1, 32'h12345137));
    vecs.push_back(mk(K_JAL,    3'd0, 1'b0, 5'd1,  5'd0, 5'd0,  32'd8,          1'b1, 32'h008000EF));
    vecs.push_back(mk(K_BRANCH, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2,  -32'sd4,        1'b1, 32'hFE208EE3));
    vecs.push_back(mk(K_BRANCH, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2,  -32'sd3,        1'b0, 32'h0));
    vecs.push_back(mk(K_OP,     3'd0, 1'b1, 5'd3,  5'd1, 5'd2,  32'd0,          1'b1, 32'h402081B3));
    vecs.push_back(mk(K_OP_IMM, 3'd5, 1'b1, 5'd5,  5'd6, 5'd0,  32'd3,          1'b1, 32'h40335293));
    vecs.push_back(mk(K_OP_IMM, 3'd1, 1'b1, 5'd5,  5'd6, 5'd0,  32'd3,          1'b0, 32'h0));
    vecs.push_back(mk(K_LOAD,   3'd2, 1'b0, 5'd10, 5'd2, 5'd0,  -32'sd8,        1'b1, 32'hFF812503));
    vecs.push_back(mk(K_LOAD,   3'd3, 1'b0, 5'd10, 5'd2, 5'd0,  32'd0,          1'b0, 32'h0));
    vecs.push_back(mk(K_STORE,  3'd2, 1'b0, 5'd0,  5'd2, 5'd10, 32'd12,         1'b1, 32'h00A12623));
    vecs.push_back(mk(K_OP_IMM, 3'd0, 1'b0, 5'd1,  5'd1, 5'd0,  32'd2048,       1'b0, 32'h0));
    vecs.push_back(mk(K_OP_IMM, 3'd0, 1'b0, 5'd1,  5'd1, 5'd0,  -32'sd2048,     1'b1, 32'h80008093));
    vecs.push_back(mk(K_JALR,   3'd0, 1'b0, 5'd0,  5'd1, 5'd0,  32'd0,          1'b1, 32'h00008067));
    vecs.push_back(mk(K_AUIPC,  3'd0, 1'b0, 5'd3,  5'd0, 5'd0,  32'h00001000,   1'b1, 32'h00001197));
    vecs.push_back(mk(K_LUI,    3'd0, 1'b0, 5'd3,  5'd0, 5'd0,  32'h00000123,   1'b0, 32'h0));
    vecs.push_back(mk(K_CSR,    3'd1, 1'b0, 5'd0,  5'd5, 5'd0,  32'h305,        1'b1, 32'h30529073));
    vecs.push_back(mk(K_CSR,    3'd4, 1'b0, 5'd0,  5'd5, 5'd0,  32'h305,        1'b0, 32'h0));
    vecs.push_back(mk(K_FIRE,   3'd0, 1'b0, 5'd1,  5'd2, 5'd0,  32'd4,          1'b1, 32'h004120AF));
    vecs.push_back(mk(K_SEND,   3'd0, 1'b0, 5'd0,  5'd3, 5'd4,  32'd0,          1'b1, 32'h0041802F));
    vecs.push_back(mk(4'hF,     3'd0, 1'b0, 5'd1,  5'd1, 5'd1,  32'd0,          1'b0, 32'h0));
    vecs.push_back(mk(K_JAL,    3'd0, 1'b0, 5'd0,  5'd0, 5'd0,  -32'sd2,        1'b1, 32'hFFFFF06F));
    vecs.push_back(mk(K_JAL,    3'd0, 1'b0, 5'd0,  5'd0, 5'd0,  32'h00100000,   1'b0, 32'h0));
    vecs.push_back(mk(K_LOAD,   3'd0, 1'b1, 5'd1,  5'd1, 5'd0,  32'd0,          1'b0, 32'h0));
`ifdef ENC_MULDIV_EN
    vecs.push_back(mk(K_OP_M,   3'd0, 1'b0, 5'd3,  5'd1, 5'd2,  32'd0,          1'b1, 32'h022081B3));
`else
    vecs.push_back(mk(K_OP_M,   3'd0, 1'b0, 5'd3,  5'd1, 5'd2,  32'd0,          1'b0, 32'h0));
`endif

    // reset values
    @(negedge clk);
    check32("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    check32("rst_we",        {31'b0, mem_we_o}, 32'd0);
    @(negedge clk);
    check32("rst_addr",      mem_addr_o, 32'h0);
    check32("rst_wdata",     mem_wdata_o, 32'h0);
    check32("rst_busy",      {31'b0, busy_o}, 32'd0);
    check32("rst_err",       {31'b0, err_o}, 32'd0);
    check32("rst_count",     {16'b0, count_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    check32("post_rst_ready", {31'b0, cmd_ready_o}, 32'd1);

    // latency: handshake edge -> mem_we_o two cycles later; low address bits dropped
    do_start(32'h0000_0203);
    exp_q.push_back({32'h0000_0200, 32'h00500093});
    send(vecs[0]);
    @(negedge clk);
    check32("lat_we_1", {31'b0, mem_we_o}, 32'd0);
    @(negedge clk);
    check32("lat_we_2", {31'b0, mem_we_o}, 32'd1);
    wait_drain();
    check32("lat_count", {16'b0, count_o}, 32'd1);
    check32("lat_addr",  mem_addr_o, 32'h0000_0204);

    // table-driven vectors, one per start
    foreach (vecs[i]) begin
      v = vecs[i];
      st_addr = 32'h0000_1000 + 32'(i * 16);
      do_start(st_addr);
      check32("vec_err_clr", {31'b0, err_o}, 32'd0);
      if (v.legal) begin
        exp_q.push_back({st_addr, v.word});
        send(v);
        wait_drain();
        check32("vec_count", {16'b0, count_o}, 32'd1);
        check32("vec_err",   {31'b0, err_o}, 32'd0);
      end else begin
        send(v);
        tick(4);
        check32("vec_ill_err",   {31'b0, err_o}, 32'd1);
        check32("vec_ill_count", {16'b0, count_o}, 32'd0);
        check32("vec_ill_busy",  {31'b0, busy_o}, 32'd0);
      end
    end

    // back-to-back LUI then JAL
    do_start(32'h0000_0400);
    exp_q.push_back({32'h0000_0400, 32'h12345137});
    exp_q.push_back({32'h0000_0404, 32'h008000EF});
    send(vecs[1]);
    send(vecs[2]);
    wait_drain();
    check32("b2b_count", {16'b0, count_o}, 32'd2);
    check32("b2b_addr",  mem_addr_o, 32'h0000_0408);

    // backpressure: RAM stalled for 20 cycles while 6 commands are offered
    do_start(32'h0000_0800);
    mem_ready_i = 1'b0;
    accepted = 0;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back({32'h0000_0800 + 32'((k - 1) * 4), (32'(k) << 20) | (32'(k) << 7) | 32'h13});
    end
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send(mk(K_OP_IMM, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k), 1'b1, 32'h0));
        end
      end
      begin
        st_seen = 1'b0;
        st_stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (mem_we_o) begin
            if (!st_seen) begin
              st_a0 = mem_addr_o;
              st_d0 = mem_wdata_o;
              st_seen = 1'b1;
            end else if (mem_addr_o !== st_a0 || mem_wdata_o !== st_d0) begin
              st_stable = 1'b0;
            end
          end
        end
        check32("bp_accepted", 32'(accepted), 32'd5);
        check32("bp_ready",    {31'b0, cmd_ready_o}, 32'd0);
        check32("bp_stable",   {31'b0, st_seen && st_stable}, 32'd1);
        check32("bp_addr0",    st_a0, 32'h0000_0800);
        check32("bp_data0",    st_d0, 32'h00100093);
        @(posedge clk);
        #1;
        mem_ready_i = 1'b1;
      end
    join
    wait_drain();
    check32("bp_count", {16'b0, count_o}, 32'd6);
    check32("bp_addr",  mem_addr_o, 32'h0000_0818);

    // start while busy is ignored and flags an error
    do_start(32'h0000_0900);
    mem_ready_i = 1'b0;
    exp_q.push_back({32'h0000_0900, 32'h00500093});
    send(vecs[0]);
    tick(3);
    start_i = 1'b1;
    start_addr_i = 32'h0000_0A00;
    @(negedge clk);
    check32("sb_ready", {31'b0, cmd_ready_o}, 32'd0);
    tick(1);
    start_i = 1'b0;
    check32("sb_err",  {31'b0, err_o}, 32'd1);
    check32("sb_addr", mem_addr_o, 32'h0000_0900);
    mem_ready_i = 1'b1;
    wait_drain();
    check32("sb_count",   {16'b0, count_o}, 32'd1);
    check32("sb_err_hold", {31'b0, err_o}, 32'd1);

    // reset during a pending write drops everything
    do_start(32'h0000_0B00);
    mem_ready_i = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    tick(3);
    check32("rw_we_before", {31'b0, mem_we_o}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check32("rw_we",    {31'b0, mem_we_o}, 32'd0);
    check32("rw_busy",  {31'b0, busy_o}, 32'd0);
    check32("rw_addr",  mem_addr_o, 32'h0);
    check32("rw_count", {16'b0, count_o}, 32'd0);
    mem_ready_i = 1'b1;
    tick(5);
    check32("rw_idle",  {31'b0, busy_o}, 32'd0);
    check32("final_q",  exp_q.size(), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
